// File: rtl/conv_pkg.sv
// Shared definitions for the int4 convolution datapath: pixel width,
// window geometry and the packing of a 3x3 window into a flat 36-bit word.
package conv_pkg;

  localparam int PIX_W    = 4;
  localparam int WIN_K    = 3;
  localparam int WIN_BITS = PIX_W * WIN_K * WIN_K;
  localparam int ACC_W    = 12;

  typedef logic [PIX_W-1:0] pix_t;

  // One window column; index 0 is the oldest row, WIN_K-1 the newest.
  typedef pix_t [WIN_K-1:0] col_t;

  // LSB of element (row i, column j), both 1-based; i=1 is the oldest row,
  // j=1 the oldest column.
  function automatic int win_idx(input int i, input int j);
    return PIX_W * (WIN_K * (i - 1) + (j - 1));
  endfunction

endpackage

// File: rtl/cal_linebuf_int4.sv
// Single-port line buffer for int4 pixels: combinational read and
// synchronous write at the same address, so a read in a write cycle
// returns the old contents (read-before-write).
module cal_linebuf_int4
  import conv_pkg::*;
#(
  parameter int DEPTH = 28,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [PIX_W-1:0] wdata,
  output logic [PIX_W-1:0] rdata
);

  pix_t mem [DEPTH];

  assign rdata = mem[addr];

  // Store the incoming pixel at the current column.
  // NOTE: storage arrays get no reset so they map onto plain RAM; the
  // window gating upstream guarantees stale entries are never emitted.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/conv_window_gen_3x3.sv
// Streaming 3x3 window generator for raster-order int4 pixels.
// Two line buffers hold the previous rows; a 3-column register window
// shifts on every accepted pixel and each complete (unpadded) window is
// emitted one cycle after its last pixel.
// Optional build macro WIN_POS_EN adds win_x/win_y, the top-left
// coordinate of the emitted window.
module conv_window_gen_3x3
  import conv_pkg::*;
#(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PIX_W-1:0]    pix_in,
  input  logic                pix_valid,
  output logic [WIN_BITS-1:0] win_out,
  output logic                win_valid,
  output logic                frame_done
`ifdef WIN_POS_EN
  ,
  output logic [$clog2(IMG_W)-1:0] win_x,
  output logic [$clog2(IMG_H)-1:0] win_y
`endif
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  logic [COL_W-1:0]    col;
  logic [ROW_W-1:0]    row;
  pix_t                lb0_rd;
  pix_t                lb1_rd;
  logic                lb_we;
  col_t                win_c1, win_c2, win_c3;
  col_t                new_col;
  logic [WIN_BITS-1:0] win_next;
  logic                emit;
  logic                last_pix;

  // Line buffers never write while reset is held.
  assign lb_we = pix_valid & ~rst;

  // lb0 carries row r-1; lb1 is fed from lb0's old contents and carries r-2.
  cal_linebuf_int4 #(.DEPTH(IMG_W)) u_lb0 (
    .clk   (clk),
    .we    (lb_we),
    .addr  (col),
    .wdata (pix_in),
    .rdata (lb0_rd)
  );

  cal_linebuf_int4 #(.DEPTH(IMG_W)) u_lb1 (
    .clk   (clk),
    .we    (lb_we),
    .addr  (col),
    .wdata (lb0_rd),
    .rdata (lb1_rd)
  );

  // Assemble the incoming column and the packed window it completes.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    new_col    = '0;
    win_next   = '0;
    new_col[0] = lb1_rd;
    new_col[1] = lb0_rd;
    new_col[2] = pix_in;
    for (int i = 1; i <= WIN_K; i++) begin
      win_next[win_idx(i, 1) +: PIX_W] = win_c2[i-1];
      win_next[win_idx(i, 2) +: PIX_W] = win_c3[i-1];
      win_next[win_idx(i, 3) +: PIX_W] = new_col[i-1];
    end
  end

  assign emit     = pix_valid && (row >= ROW_W'(2)) && (col >= COL_W'(2));
  assign last_pix = (row == ROW_LAST) && (col == COL_LAST);

  // Raster position of the pixel being accepted; wraps at end of frame.
  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (pix_valid) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  // Shift the window on each pixel and register the emitted window.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_c1     <= '0;
      win_c2     <= '0;
      win_c3     <= '0;
      win_out    <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
`ifdef WIN_POS_EN
      win_x      <= '0;
      win_y      <= '0;
`endif
    end else begin
      win_valid  <= emit;
      frame_done <= emit && last_pix;
      if (pix_valid) begin
        win_c1 <= win_c2;
        win_c2 <= win_c3;
        win_c3 <= new_col;
      end
      if (emit) begin
        win_out <= win_next;
`ifdef WIN_POS_EN
        win_x   <= col - COL_W'(2);
        win_y   <= row - ROW_W'(2);
`endif
      end
    end
  end

endmodule

// File: tb/tb_conv_window_gen_3x3.sv
// Scoreboard bench for conv_window_gen_3x3 on a 5x4 image.
// The driver pushes the hand-computed window for every pixel that
// completes one; the monitor pops and compares on each win_valid and
// checks that idle cycles neither emit nor disturb win_out.
module tb_conv_window_gen_3x3;

  localparam int W = 5;
  localparam int H = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  pix_in;
  logic        pix_valid;
  logic [35:0] win_out;
  logic        win_valid;
  logic        frame_done;
`ifdef WIN_POS_EN
  logic [2:0]  win_x;
  logic [1:0]  win_y;
`endif

  always #5 clk = ~clk;

  conv_window_gen_3x3 #(.IMG_W(W), .IMG_H(H)) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .win_out    (win_out),
    .win_valid  (win_valid),
    .frame_done (frame_done)
`ifdef WIN_POS_EN
    ,
    .win_x      (win_x),
    .win_y      (win_y)
`endif
  );

  typedef struct {
    logic [35:0] win;
    logic        fd;
    int          x;
    int          y;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  int checks   = 0;
  int errors   = 0;
  int win_seen = 0;
  int fd_seen  = 0;

  // Hand-computed windows, raster order of top-left corner.
  // Frame with pixel = (r*5+c) & 0xF, and the same frame plus one.
  logic [35:0] exp_tab0 [6] = '{36'hCBA765210, 36'hDCB876321, 36'hEDC987432,
                                36'h10FCBA765, 36'h210DCB876, 36'h321EDC987};
  logic [35:0] exp_tab1 [6] = '{36'hDCB876321, 36'hEDC987432, 36'hFEDA98543,
                                36'h210DCB876, 36'h321EDC987, 36'h432FEDA98};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor -------------------------------------------------------------
  logic        pv_s;
  logic        rst_s;
  logic [35:0] last_win;

  always @(posedge clk) begin
    pv_s  <= pix_valid;
    rst_s <= rst;
  end

  always @(negedge clk) begin
    if (win_valid) begin
      win_seen++;
      if (frame_done) fd_seen++;
      if (sb_q.size() == 0) begin
        check("unexpected_win_valid", 64'(win_valid), 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("win_out", 64'(win_out), 64'(mon_e.win));
        check("frame_done", 64'(frame_done), 64'(mon_e.fd));
`ifdef WIN_POS_EN
        check("win_x", 64'(win_x), 64'(mon_e.x));
        check("win_y", 64'(win_y), 64'(mon_e.y));
`endif
      end
    end else if (frame_done) begin
      check("frame_done_without_valid", 64'(frame_done), 64'd0);
    end
    if (pv_s === 1'b0 && rst_s === 1'b0) begin
      check("gap_win_valid", 64'(win_valid), 64'd0);
      check("gap_win_out_stable", 64'(win_out), 64'(last_win));
    end
    last_win = win_out;
  end

  // Driver --------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int r, input int c, input int off, input int max_gap);
    int   g;
    exp_t e;
    g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    if (g > 0) begin
      pix_valid = 1'b0;
      repeat (g) tick();
    end
    pix_valid = 1'b1;
    pix_in    = 4'(r * W + c + off);
    if (r >= 2 && c >= 2) begin
      e.win = (off != 0) ? exp_tab1[(r-2)*3 + (c-2)] : exp_tab0[(r-2)*3 + (c-2)];
      e.fd  = (r == H-1) && (c == W-1);
      e.x   = c - 2;
      e.y   = r - 2;
      sb_q.push_back(e);
    end
    tick();
  endtask

  task automatic send_frame(input int off, input int max_gap);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        send(r, c, off, max_gap);
  endtask

  task automatic drain_and_check(input string tag, input int n_win, input int n_fd);
    pix_valid = 1'b0;
    repeat (4) tick();
    check({tag, "_windows"}, 64'(win_seen), 64'(n_win));
    check({tag, "_frame_done"}, 64'(fd_seen), 64'(n_fd));
    check({tag, "_queue_empty"}, 64'(sb_q.size()), 64'd0);
    win_seen = 0;
    fd_seen  = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held two cycles with pixels offered: nothing may move.
    rst       = 1'b1;
    pix_valid = 1'b1;
    pix_in    = 4'hF;
    tick();
    tick();
    check("reset_win_out", 64'(win_out), 64'd0);
    check("reset_win_valid", 64'(win_valid), 64'd0);
    check("reset_frame_done", 64'(frame_done), 64'd0);
    rst       = 1'b0;
    pix_valid = 1'b0;
    tick();

    // Continuous stream, one frame.
    send_frame(0, 0);
    drain_and_check("t1", 6, 1);

    // Same frame with random idle gaps.
    send_frame(0, 3);
    drain_and_check("t2", 6, 1);

    // Two back-to-back frames, second one offset by +1.
    send_frame(0, 0);
    send_frame(1, 0);
    drain_and_check("t3", 12, 2);

    // Reset after pixel (3,1), then a full frame.
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        if (r < 3 || (r == 3 && c <= 1)) send(r, c, 0, 0);
    rst       = 1'b1;
    pix_valid = 1'b1;
    pix_in    = 4'h9;
    tick();
    rst       = 1'b0;
    pix_valid = 1'b0;
    tick();
    send_frame(0, 0);
    drain_and_check("t4", 9, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
